// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the EX-stage operand muxes.
// Define FWD_STALL_CNT_EN to build the saturating stall-cycle counter on stall_cnt_o.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [REG_W-1:0] ZERO_REG  = {REG_W{1'b0}};
  localparam logic [1:0]       SEL_RF    = 2'd0;
  localparam logic [1:0]       SEL_MEMWB = 2'd1;
  localparam logic [1:0]       SEL_EXMEM = 2'd2;

  logic [REG_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_W-1:0] idex_dst_q, idex_dst_d;
  logic             idex_rw_q, idex_rw_d;
  logic             idex_mr_q, idex_mr_d;
  logic [REG_W-1:0] exmem_dst_q, exmem_dst_d;
  logic             exmem_rw_q, exmem_rw_d;
  logic [REG_W-1:0] memwb_dst_q, memwb_dst_d;
  logic             memwb_rw_q, memwb_rw_d;
  logic             stall_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  // Nearest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] em_dst,
    input logic             em_rw,
    input logic [REG_W-1:0] mw_dst,
    input logic             mw_rw
  );
    logic [1:0] sel;
    if (em_rw && (em_dst != ZERO_REG) && (em_dst == src)) begin
      sel = SEL_EXMEM;
    end else if (mw_rw && (mw_dst != ZERO_REG) && (mw_dst == src)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection; a flush squashes the consumer so it never stalls.
  always_comb begin
    stall_s = 1'b0;
    if (flush_i) begin
      stall_s = 1'b0;
    end else if (idex_mr_q && (idex_dst_q != ZERO_REG) &&
                 ((idex_dst_q == id_rs_i) || (idex_dst_q == id_rt_i))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Operand selects from the registered shadow stages.
  always_comb begin
    fwd_a_s = fwd_sel(idex_rs_q, exmem_dst_q, exmem_rw_q, memwb_dst_q, memwb_rw_q);
    fwd_b_s = fwd_sel(idex_rt_q, exmem_dst_q, exmem_rw_q, memwb_dst_q, memwb_rw_q);
  end

  // Shadow pipeline advance with bubble insertion on stall or flush.
  always_comb begin
    exmem_dst_d = idex_dst_q;
    exmem_rw_d  = idex_rw_q;
    memwb_dst_d = exmem_dst_q;
    memwb_rw_d  = exmem_rw_q;
    idex_rs_d   = id_rs_i;
    idex_rt_d   = id_rt_i;
    idex_dst_d  = id_dst_i;
    idex_rw_d   = id_regwrite_i;
    idex_mr_d   = id_memread_i;
    if (stall_s || flush_i) begin
      idex_rs_d  = ZERO_REG;
      idex_rt_d  = ZERO_REG;
      idex_dst_d = ZERO_REG;
      idex_rw_d  = 1'b0;
      idex_mr_d  = 1'b0;
    end else begin
      idex_rs_d  = id_rs_i;
      idex_rt_d  = id_rt_i;
      idex_dst_d = id_dst_i;
      idex_rw_d  = id_regwrite_i;
      idex_mr_d  = id_memread_i;
    end
  end

  // Shadow stage registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_rs_q   <= ZERO_REG;
      idex_rt_q   <= ZERO_REG;
      idex_dst_q  <= ZERO_REG;
      idex_rw_q   <= 1'b0;
      idex_mr_q   <= 1'b0;
      exmem_dst_q <= ZERO_REG;
      exmem_rw_q  <= 1'b0;
      memwb_dst_q <= ZERO_REG;
      memwb_rw_q  <= 1'b0;
    end else begin
      idex_rs_q   <= idex_rs_d;
      idex_rt_q   <= idex_rt_d;
      idex_dst_q  <= idex_dst_d;
      idex_rw_q   <= idex_rw_d;
      idex_mr_q   <= idex_mr_d;
      exmem_dst_q <= exmem_dst_d;
      exmem_rw_q  <= exmem_rw_d;
      memwb_dst_q <= memwb_dst_d;
      memwb_rw_q  <= memwb_rw_d;
    end
  end

  assign fwd_a_o = fwd_a_s;
  assign fwd_b_o = fwd_b_s;
  assign stall_o = stall_s;

`ifdef FWD_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed hazard scenarios plus random
// instruction streams compared against a stage-list reference model.
module tb_fwd_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  id_rs_i = 5'd0, id_rt_i = 5'd0, id_dst_i = 5'd0;
  logic        id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
  logic [4:0] m_dst[3];
  bit         m_rw[3];
  logic [4:0] m_rs, m_rt;
  bit         m_mr;
  int         m_cnt;
  bit         exp_stall;

  fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_dst_i(id_dst_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    for (int s = 1; s <= 2; s++) begin
      if (m_rw[s] && m_dst[s] != 5'd0 && m_dst[s] == src) return (s == 1) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 3; s++) begin
      m_dst[s] = 5'd0;
      m_rw[s]  = 1'b0;
    end
    m_rs = 5'd0; m_rt = 5'd0; m_mr = 1'b0; m_cnt = 0; exp_stall = 1'b0;
  endfunction

  // Apply one ID-stage instruction mid-cycle and compare all outputs with the model.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic fl);
    @(negedge clk_i);
    id_rs_i = rs; id_rt_i = rt; id_dst_i = dst;
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    #1;
    exp_stall = !fl && m_mr && m_dst[0] != 5'd0 && (m_dst[0] == rs || m_dst[0] == rt);
    check("fwd_a", 32'(fwd_a_o), 32'(model_fwd(m_rs)));
    check("fwd_b", 32'(fwd_b_o), 32'(model_fwd(m_rt)));
    check("stall", 32'(stall_o), 32'(exp_stall));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk_i);
`ifdef FWD_STALL_CNT_EN
    if (exp_stall && m_cnt != 65535) m_cnt++;
`endif
    m_dst[2] = m_dst[1]; m_rw[2] = m_rw[1];
    m_dst[1] = m_dst[0]; m_rw[1] = m_rw[0];
    if (exp_stall || flush_i) begin
      m_dst[0] = 5'd0; m_rw[0] = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_mr = 1'b0;
    end else begin
      m_dst[0] = id_dst_i; m_rw[0] = id_regwrite_i; m_rs = id_rs_i; m_rt = id_rt_i;
      m_mr = id_memread_i;
    end
  endtask

  // Hold reset for 3 cycles with random ID inputs, then release just before an edge.
  task automatic do_reset();
    rst_i = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      id_rs_i = 5'($urandom); id_rt_i = 5'($urandom); id_dst_i = 5'($urandom);
      id_regwrite_i = 1'($urandom); id_memread_i = 1'($urandom); flush_i = 1'b0;
      #1;
      check("rst_fwd_a", 32'(fwd_a_o), 32'd0);
      check("rst_fwd_b", 32'(fwd_b_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    end
    rst_i = 1'b1;
    exp_stall = 1'b0;
    tick();
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    do_reset();
    nop(); nop(); nop();

    // EX/MEM forward
    drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd8, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("exmem_a", 32'(fwd_a_o), 32'd2);
    check("exmem_b", 32'(fwd_b_o), 32'd0);
    tick(); nop(); nop();

    // Priority: both stages write r8
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("prio_a", 32'(fwd_a_o), 32'd2);
    check("prio_b", 32'(fwd_b_o), 32'd2);
    tick(); nop(); nop();

    // MEM/WB forward with an unrelated instruction in between
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("memwb_a", 32'(fwd_a_o), 32'd1);
    check("memwb_b", 32'(fwd_b_o), 32'd1);
    tick(); nop(); nop();

    // Register zero is never forwarded
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("r0_exmem", 32'(fwd_a_o), 32'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("r0_memwb", 32'(fwd_a_o), 32'd0);
    tick(); nop(); nop();

    // Load-use: one stall cycle, then MEM/WB forward
    drive(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); tick();
    drive(5'd3, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 32'(stall_o), 32'd1);
    tick();
    drive(5'd3, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    check("lu_stall_drop", 32'(stall_o), 32'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_fwd_b", 32'(fwd_b_o), 32'd1);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", 32'(stall_cnt_o), 32'd1);
`else
    check("lu_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    tick(); nop(); nop();

    // Flush wins over stall
    drive(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); tick();
    drive(5'd3, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1);
    check("fl_stall", 32'(stall_o), 32'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("fl_bubble_b", 32'(fwd_b_o), 32'd0);
    tick(); nop(); nop();

    // Reset during a stall
    drive(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0); tick();
    drive(5'd12, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    check("mid_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_cnt", 32'(stall_cnt_o), 32'd0);
    do_reset();

    // Random streams over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
